sum90_ctrl: RTL and testbench
=============================

Name: sum90_ctrl

Overview:
Sequencing controller for the 7x13 centre-excluded window-sum pipeline (sum90). It tracks row and column position over a raster pixel stream and asserts the window-sum enable only when a full 7x13 window lies inside the image. It carries a valid token and the window-centre coordinates through the 4-cycle summation latency, and reports frame completion. It sits between the line-buffer/window-register stage and the over-exposure decision logic.

Parameters:
DW_PART, 9, per-tap pixel width; the window sum is DW_PART+7 bits.
CW, 12, width of the coordinate counters and the cfg_width/cfg_height fields.
WIN_H, 7, window height in rows.
WIN_W, 13, window width in columns.
LAT, 4, sum pipeline latency in cycles, from the enable cycle to the result-valid cycle.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cfg_width  in  CW  image width in pixels; sampled on frame_start
cfg_height  in  CW  image height in lines; sampled on frame_start
frame_start  in  1  one-cycle pulse that starts a frame
pix_valid  in  1  a raster-order pixel is presented this cycle
sum90_en  out  1  enable for the window-sum stage-1 registers
sum90_in  in  DW_PART+7  window-sum result from the datapath
sum_valid  out  1  sum_out, cen_x and cen_y are valid this cycle
sum_out  out  DW_PART+7  sum90_in passed through combinationally
cen_x  out  CW  column of the window centre for sum_out
cen_y  out  CW  row of the window centre for sum_out
frame_done  out  1  one-cycle pulse coincident with the final result slot of a frame
busy  out  1  high whenever the state is not IDLE
err_unexp  out  1  one-cycle pulse when pix_valid arrives in IDLE or FLUSH

Behaviour:
- Reset (rst high, asynchronous) clears all state:
  - state = IDLE; col, row, flush counter, valid pipe and coordinate pipes = 0.
  - All registered outputs read 0.
- The datapath reset is driven by the inverted rst at the top level.
- State machine:
  - IDLE -> FILL on frame_start. Latch cfg_width/cfg_height; clear col and row.
  - FILL: rows 0..WIN_H-2. Count pixels; sum90_en = 0. When row reaches WIN_H-1, go to RUN.
  - RUN: sum90_en = pix_valid AND col >= WIN_W-1 (combinational, same cycle as the pixel).
  - FLUSH: count exactly LAT cycles; frame_done is asserted in the LAT-th cycle, then go to IDLE.
- Counting: on each pix_valid, col increments. At col = W-1, col wraps to 0 and row increments.
- Last pixel (col = W-1, row = H-1) accepted in cycle c, from FILL or RUN:
  - FLUSH is entered in cycle c+1.
  - frame_done is high in cycle c+LAT and coincides with the last sum_valid, if any.
  - busy is low from cycle c+LAT+1.
- Valid pipe: a LAT-bit shift register, free-running every cycle, with stage 0 loaded from sum90_en.
  - sum_valid = stage LAT-1. An enable in cycle c gives sum_valid in cycle c+LAT.
  - The coordinate pipes are in lockstep with the valid pipe. Centre at enable = (col-(WIN_W-1)/2, row-(WIN_H-1)/2) = (col-6, row-3).
- Degenerate sizes (cfg_width < WIN_W or cfg_height < WIN_H): sum90_en is never asserted. frame_done still follows the last pixel as above.
- frame_start outside IDLE aborts the current frame:
  - Clear the valid pipe (drops in-flight results).
  - Re-latch the configuration and enter FILL in the same edge.
- Simultaneous last pixel and frame_start: frame_start wins; no frame_done is produced.
- pix_valid in IDLE or FLUSH: the pixel is ignored, counters do not move, and err_unexp pulses for one cycle.
- Mid-frame reset: immediate return to IDLE; no frame_done.
- Width rules:
  - cfg values of 0 or 1 are illegal configurations and need not be handled.
  - Counters never exceed cfg-1.
  - Centre subtraction is only evaluated when sum90_en is high, so it never underflows.

Decomposition:
- Package sum90_pkg holds:
  - state encoding (IDLE, FILL, RUN, FLUSH);
  - WIN_H, WIN_W, LAT, and the derived half-window offsets (6, 3).
- Sub-module: sum90_valid_pipe, the LAT-deep shift register carrying {valid, cen_x, cen_y} with a synchronous flush input.
- The FSM and counters stay in sum90_ctrl.

Test Plan:
- Normal frame, 16x8 (frame_start, then 128 contiguous pix_valid):
  - exactly 8 sum90_en pulses;
  - first enable at row 6, col 12, giving sum_valid 4 cycles later with centre (6,3);
  - last centre (9,4);
  - frame_done coincident with the 8th sum_valid;
  - busy low the next cycle.
- Gapped input, same frame with pix_valid low every other cycle: the same 8 enables and coordinates; sum_out equals sum90_in in each sum_valid cycle.
- Degenerate frame, 12x8 then 16x6: zero enables; frame_done exactly 4 cycles after the last pixel.
- Abort: frame_start asserted 2 cycles after an enable in RUN:
  - that token never produces sum_valid;
  - counters restart at (0,0);
  - the new frame completes normally.
- Protocol error: pix_valid in IDLE and in FLUSH gives err_unexp pulses; counters and frame_done timing are unaffected.
- Reset mid-RUN with rst high for 1 cycle: all outputs 0 at once; the next frame_start behaves as a fresh frame.

Source files
------------

// File: rtl/sum90_pkg.sv
// sum90_pkg: window geometry, summation latency and controller state encoding for the sum90 pipeline.
// Shared by the sequencing controller and its centre-coordinate pipe.
package sum90_pkg;

    localparam int WIN_H  = 7;
    localparam int WIN_W  = 13;
    localparam int LAT    = 4;
    localparam int HALF_W = (WIN_W - 1) / 2;
    localparam int HALF_H = (WIN_H - 1) / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/sum90_valid_pipe.sv
// sum90_valid_pipe: DEPTH-stage shift register carrying {valid, cen_x, cen_y} alongside the window sum.
// Latency DEPTH cycles, free-running with no backpressure; flush empties every stage on the next edge.
module sum90_valid_pipe
    import sum90_pkg::*;
#(
    parameter int CW    = 12,
    parameter int DEPTH = LAT
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          flush,
    input  logic          in_vld,
    input  logic [CW-1:0] in_x,
    input  logic [CW-1:0] in_y,
    output logic          out_vld,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y
);

    logic [DEPTH-1:0] vld_q;
    logic [CW-1:0]    x_q [DEPTH];
    logic [CW-1:0]    y_q [DEPTH];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            vld_q  <= {vld_q[DEPTH-2:0], in_vld};
            x_q[0] <= in_x;
            y_q[0] <= in_y;
            for (int i = 1; i < DEPTH; i++) begin
                x_q[i] <= x_q[i-1];
                y_q[i] <= y_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_x   = x_q[DEPTH-1];
    assign out_y   = y_q[DEPTH-1];

endmodule

// File: rtl/sum90_ctrl.sv
// sum90_ctrl: raster position tracking and 7x13 window-sum sequencing; enable is same-cycle, results follow 4 cycles later.
// No backpressure: a pixel is accepted in every cycle pix_valid is high; frame_start aborts any frame in progress.
module sum90_ctrl
    import sum90_pkg::*;
#(
    parameter int DW_PART = 9,
    parameter int CW      = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CW-1:0]        cfg_width,
    input  logic [CW-1:0]        cfg_height,
    input  logic                 frame_start,
    input  logic                 pix_valid,
    output logic                 sum90_en,
    input  logic [DW_PART+6:0]   sum90_in,
    output logic                 sum_valid,
    output logic [DW_PART+6:0]   sum_out,
    output logic [CW-1:0]        cen_x,
    output logic [CW-1:0]        cen_y,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 err_unexp
);

    localparam int FCW = $clog2(LAT);

    state_t         state;
    logic [CW-1:0]  col;
    logic [CW-1:0]  row;
    logic [CW-1:0]  w_q;
    logic [CW-1:0]  h_q;
    logic [FCW-1:0] fcnt;
    logic           last_col;
    logic           last_row;
    logic [CW-1:0]  en_x;
    logic [CW-1:0]  en_y;
    logic           rst_n;

    assign rst_n    = ~rst;
    assign last_col = (col == w_q - CW'(1));
    assign last_row = (row == h_q - CW'(1));
    assign busy     = (state != IDLE);
    assign sum_out  = sum90_in;

    // RUN is only reachable once WIN_H-1 rows are buffered, so the column test completes the window check.
    assign sum90_en = (state == RUN) && pix_valid && (col >= CW'(WIN_W - 1));
    assign en_x     = sum90_en ? col - CW'(HALF_W) : '0;
    assign en_y     = sum90_en ? row - CW'(HALF_H) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            fcnt       <= '0;
            frame_done <= 1'b0;
            err_unexp  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_unexp  <= 1'b0;
            if (frame_start) begin
                w_q       <= cfg_width;
                h_q       <= cfg_height;
                col       <= '0;
                row       <= '0;
                fcnt      <= '0;
                state     <= FILL;
                err_unexp <= pix_valid && (state == IDLE || state == FLUSH);
            end else begin
                case (state)
                    IDLE: begin
                        err_unexp <= pix_valid;
                    end
                    FILL, RUN: begin
                        if (pix_valid) begin
                            if (last_col) begin
                                col <= '0;
                                if (last_row) begin
                                    row   <= '0;
                                    fcnt  <= '0;
                                    state <= FLUSH;
                                end else begin
                                    row <= row + CW'(1);
                                    if (state == FILL && row == CW'(WIN_H - 2))
                                        state <= RUN;
                                end
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    FLUSH: begin
                        err_unexp <= pix_valid;
                        fcnt      <= fcnt + FCW'(1);
                        // Registered pulse lands in the final flush cycle, aligned with the last result.
                        if (fcnt == FCW'(LAT - 2))
                            frame_done <= 1'b1;
                        if (fcnt == FCW'(LAT - 1))
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sum90_valid_pipe #(
        .CW    (CW),
        .DEPTH (LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .arst_n  (rst_n),
        .flush   (frame_start && busy),
        .in_vld  (sum90_en),
        .in_x    (en_x),
        .in_y    (en_y),
        .out_vld (sum_valid),
        .out_x   (cen_x),
        .out_y   (cen_y)
    );

endmodule

// File: tb/tb_sum90_ctrl.sv
// tb_sum90_ctrl: scoreboard bench for sum90_ctrl; expected centres are queued as pixels are driven.
// A negedge monitor pops and compares them when sum_valid appears.
module tb_sum90_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] cfg_width = '0;
    logic [11:0] cfg_height = '0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic        sum90_en;
    logic [15:0] sum90_in = '0;
    logic        sum_valid;
    logic [15:0] sum_out;
    logic [11:0] cen_x;
    logic [11:0] cen_y;
    logic        frame_done;
    logic        busy;
    logic        err_unexp;

    always #5 clk = ~clk;

    sum90_ctrl #(.DW_PART(9), .CW(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .sum90_en    (sum90_en),
        .sum90_in    (sum90_in),
        .sum_valid   (sum_valid),
        .sum_out     (sum_out),
        .cen_x       (cen_x),
        .cen_y       (cen_y),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_unexp   (err_unexp)
    );

    typedef struct {
        int x;
        int y;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_on = 1'b0;
    bit exp_en = 1'b0;
    int exp_done_cyc = -1;
    int exp_err_cyc = -1;
    int last_cyc = 0;
    int mcol = 0, mrow = 0, fw = 0, fh = 0;
    int en_cnt = 0, nv = 0;
    int first_x = 0, first_y = 0, last_x = 0, last_y = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sum90_in = 16'($urandom);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("sum90_en", int'(sum90_en), int'(exp_en));
            if (sum90_en) en_cnt++;
            chk("frame_done", int'(frame_done), int'(cyc == exp_done_cyc));
            chk("err_unexp", int'(err_unexp), int'(cyc == exp_err_cyc));
            chk("sum_valid", int'(sum_valid), int'(sb_q.size() > 0 && sb_q[0].cyc == cyc));
            if (sum_valid && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("cen_x", int'(cen_x), mon_e.x);
                chk("cen_y", int'(cen_y), mon_e.y);
                chk("sum_out", int'(sum_out), int'(sum90_in));
                if (nv == 0) begin
                    first_x = int'(cen_x);
                    first_y = int'(cen_y);
                end
                last_x = int'(cen_x);
                last_y = int'(cen_y);
                nv++;
            end
        end
    end

    task automatic start_frame(input int w, input int h);
        sb_q.delete();
        exp_done_cyc = -1;
        en_cnt = 0;
        nv = 0;
        cfg_width = 12'(w);
        cfg_height = 12'(h);
        fw = w;
        fh = h;
        mcol = 0;
        mrow = 0;
        frame_start = 1'b1;
        pix_valid = 1'b0;
        exp_en = 1'b0;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic drive_pix(input int n, input bit gap);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            exp_en = (mcol >= 12 && mrow >= 6);
            if (exp_en) begin
                e.x = mcol - 6;
                e.y = mrow - 3;
                e.cyc = cyc + 4;
                sb_q.push_back(e);
            end
            if (mcol == fw - 1 && mrow == fh - 1) begin
                exp_done_cyc = cyc + 4;
                last_cyc = cyc;
            end
            tick();
            pix_valid = 1'b0;
            exp_en = 1'b0;
            if (mcol == fw - 1) begin
                mcol = 0;
                mrow++;
            end else begin
                mcol++;
            end
            if (gap) tick();
        end
    endtask

    task automatic finish_frame(input bit stray);
        if (stray) begin
            tick();
            pix_valid = 1'b1;
            exp_err_cyc = cyc + 1;
            tick();
            pix_valid = 1'b0;
        end
        for (int i = 0; i < 20 && cyc < last_cyc + 4; i++) tick();
        @(negedge clk);
        chk("busy_last_slot", int'(busy), 1);
        tick();
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        chk("sb_empty", sb_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_busy"}, int'(busy), 0);
        chk({pfx, "_sum_valid"}, int'(sum_valid), 0);
        chk({pfx, "_frame_done"}, int'(frame_done), 0);
        chk({pfx, "_err_unexp"}, int'(err_unexp), 0);
        chk({pfx, "_cen_x"}, int'(cen_x), 0);
        chk({pfx, "_cen_y"}, int'(cen_y), 0);
        chk({pfx, "_sum90_en"}, int'(sum90_en), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        rst = 1'b0;
        mon_on = 1'b1;
        tick();

        // stray pixel while idle
        pix_valid = 1'b1;
        exp_err_cyc = cyc + 1;
        tick();
        pix_valid = 1'b0;
        tick();
        tick();

        // normal 16x8 frame with a stray pixel during flush
        start_frame(16, 8);
        drive_pix(128, 1'b0);
        finish_frame(1'b1);
        chk("n16x8_en_cnt", en_cnt, 8);
        chk("n16x8_valid_cnt", nv, 8);
        chk("n16x8_first_x", first_x, 6);
        chk("n16x8_first_y", first_y, 3);
        chk("n16x8_last_x", last_x, 9);
        chk("n16x8_last_y", last_y, 4);

        // gapped 16x8 frame
        start_frame(16, 8);
        drive_pix(128, 1'b1);
        finish_frame(1'b0);
        chk("gap_en_cnt", en_cnt, 8);
        chk("gap_first_x", first_x, 6);
        chk("gap_last_y", last_y, 4);

        // degenerate frames
        start_frame(12, 8);
        drive_pix(96, 1'b0);
        finish_frame(1'b0);
        chk("deg12x8_en_cnt", en_cnt, 0);
        start_frame(16, 6);
        drive_pix(96, 1'b0);
        finish_frame(1'b0);
        chk("deg16x6_en_cnt", en_cnt, 0);

        // abort two cycles after the first enable
        start_frame(16, 8);
        drive_pix(109, 1'b0);
        chk("abort_pre_en_cnt", en_cnt, 1);
        tick();
        start_frame(16, 8);
        drive_pix(128, 1'b0);
        finish_frame(1'b0);
        chk("abort_next_en_cnt", en_cnt, 8);
        chk("abort_next_first_x", first_x, 6);

        // reset in the middle of RUN with tokens in flight
        start_frame(16, 8);
        drive_pix(110, 1'b0);
        rst = 1'b1;
        pix_valid = 1'b1;
        sb_q.delete();
        exp_done_cyc = -1;
        exp_en = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        rst = 1'b0;
        pix_valid = 1'b0;
        tick();
        start_frame(16, 8);
        drive_pix(128, 1'b0);
        finish_frame(1'b0);
        chk("postrst_en_cnt", en_cnt, 8);
        chk("postrst_last_x", last_x, 9);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
